reg_axil_master: RTL and testbench

REG_AXIL_MASTER -- requirements
Module: reg_axil_master

---
 rtl/reg_axil_pkg.sv | 47 ++++
 rtl/axil_timeout_cnt.sv | 41 ++++
 rtl/reg_axil_master.sv | 176 +++++++++++++++++
 tb/tb_reg_axil_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_axil_pkg.sv
// Shared types and constants for the register-to-AXI-Lite master.
package reg_axil_pkg;

    // Controller states, one transaction in flight at a time.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } axil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of the abort counter; wide enough for any legal timeout value.
    localparam int unsigned TMO_CNT_W = 16;

    // Every registered output of the master, kept together so one
    // register block and one default assignment cover them all.
    typedef struct packed {
        logic [31:0] awaddr;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic        arvalid;
        logic        rready;
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } axil_mst_out_t;

    // Register accesses must be 32-bit aligned.
    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    // Anything other than OKAY is treated as a failed transfer.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// Cycle counter that flags when a transaction has been busy too long.
module axil_timeout_cnt
    import reg_axil_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count busy cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the LIMIT-th busy cycle so the abort lands exactly
    // after LIMIT cycles of outstanding valid/ready.
    assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/reg_axil_master.sv
// Bridges a simple register request port onto an AXI-Lite master,
// one transaction at a time, with an abort timeout.
module reg_axil_master
    import reg_axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    // register request / response
    input  logic        reg_valid,
    input  logic        reg_write,
    input  logic [31:0] reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic [3:0]  reg_wstrb,
    output logic        reg_ready,
    output logic [31:0] reg_rdata,
    output logic        reg_error,
    // AXI-Lite write
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    // AXI-Lite read
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready
);

    axil_state_e   state_q, state_d;
    axil_mst_out_t out_q, out_d;

    logic busy;
    logic tmo_expired;
    logic aw_fin;
    logic w_fin;

    // The counter only runs while a bus transaction is outstanding and is
    // held at zero otherwise, so it always starts fresh out of IDLE.
    assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_RESP);

    axil_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!busy),
        .enable_i  (busy),
        .expired_o (tmo_expired)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_d.ready = 1'b0;
        // A channel is finished once its valid is low (already accepted)
        // or is being accepted this cycle.
        aw_fin    = !out_q.awvalid || axi_awready;
        w_fin     = !out_q.wvalid  || axi_wready;

        unique case (state_q)
            IDLE: begin
                if (reg_valid) begin
                    if (!word_aligned(reg_addr)) begin
                        // Misaligned: fail locally, never touch the bus.
                        out_d.error = 1'b1;
                        out_d.rdata = '0;
                        out_d.ready = 1'b1;
                        state_d     = DONE;
                    end else if (reg_write) begin
                        out_d.awaddr  = reg_addr;
                        out_d.wdata   = reg_wdata;
                        out_d.wstrb   = reg_wstrb;
                        out_d.awvalid = 1'b1;
                        out_d.wvalid  = 1'b1;
                        state_d       = WR_REQ;
                    end else begin
                        out_d.araddr  = reg_addr;
                        out_d.arvalid = 1'b1;
                        state_d       = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // Address and data channels retire independently.
                if (out_q.awvalid && axi_awready) out_d.awvalid = 1'b0;
                if (out_q.wvalid  && axi_wready)  out_d.wvalid  = 1'b0;
                if (aw_fin && w_fin) begin
                    out_d.bready = 1'b1;
                    state_d      = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    out_d.bready = 1'b0;
                    out_d.error  = resp_is_err(axi_bresp);
                    out_d.rdata  = '0;
                    out_d.ready  = 1'b1;
                    state_d      = DONE;
                end
            end
            RD_REQ: begin
                if (axi_arready) begin
                    out_d.arvalid = 1'b0;
                    out_d.rready  = 1'b1;
                    state_d       = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axi_rvalid) begin
                    out_d.rready = 1'b0;
                    out_d.rdata  = axi_rdata;
                    out_d.error  = resp_is_err(axi_rresp);
                    out_d.ready  = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the bus did this cycle.
        if (tmo_expired) begin
            out_d.awvalid = 1'b0;
            out_d.wvalid  = 1'b0;
            out_d.bready  = 1'b0;
            out_d.arvalid = 1'b0;
            out_d.rready  = 1'b0;
            out_d.error   = 1'b1;
            out_d.rdata   = '0;
            out_d.ready   = 1'b1;
            state_d       = DONE;
        end
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign reg_ready   = out_q.ready;
    assign reg_rdata   = out_q.rdata;
    assign reg_error   = out_q.error;
    assign axi_awaddr  = out_q.awaddr;
    assign axi_awvalid = out_q.awvalid;
    assign axi_wdata   = out_q.wdata;
    assign axi_wstrb   = out_q.wstrb;
    assign axi_wvalid  = out_q.wvalid;
    assign axi_bready  = out_q.bready;
    assign axi_araddr  = out_q.araddr;
    assign axi_arvalid = out_q.arvalid;
    assign axi_rready  = out_q.rready;

endmodule

// File: tb/tb_reg_axil_master.sv
// Directed bench for reg_axil_master with a delay-configurable AXI-Lite slave.
module tb_reg_axil_master;

    logic        clk;
    logic        rst_n;
    logic        reg_valid, reg_write;
    logic [31:0] reg_addr, reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_ready, reg_error;
    logic [31:0] reg_rdata;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    int total = 0;
    int bad   = 0;

    // slave configuration (cycles of extra wait per channel)
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

    reg_axil_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_ready(reg_ready), .reg_rdata(reg_rdata), .reg_error(reg_error),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_got, w_got, r_arm;

    assign axi_awready = axi_awvalid && (aw_cnt >= aw_dly);
    assign axi_wready  = axi_wvalid  && (w_cnt  >= w_dly);
    assign axi_arready = axi_arvalid && (ar_cnt >= ar_dly);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_arm <= 1'b0;
            axi_bvalid <= 1'b0; axi_rvalid <= 1'b0;
        end else begin
            aw_cnt <= (axi_awvalid && !axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi_wvalid  && !axi_wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (axi_arvalid && !axi_arready) ? ar_cnt + 1 : 0;
            if (axi_awvalid && axi_awready) aw_got <= 1'b1;
            if (axi_wvalid && axi_wready)   w_got  <= 1'b1;
            if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else if (!axi_bvalid && (aw_got || (axi_awvalid && axi_awready))
                                     && (w_got  || (axi_wvalid  && axi_wready))) begin
                if (b_cnt >= b_dly) axi_bvalid <= 1'b1;
                else                b_cnt <= b_cnt + 1;
            end
            if (axi_arvalid && axi_arready) r_arm <= 1'b1;
            if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0; r_arm <= 1'b0; r_cnt <= 0;
            end else if (!axi_rvalid && (r_arm || (axi_arvalid && axi_arready))) begin
                if (r_cnt >= r_dly) axi_rvalid <= 1'b1;
                else                r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- bus statistics ----------------
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int n_vld = 0, n_arv = 0, n_wonly = 0, n_unstable = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic        p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

    always @(posedge clk) begin
        if (axi_awvalid && axi_awready) begin n_aw <= n_aw + 1; last_awaddr <= axi_awaddr; end
        if (axi_wvalid && axi_wready) begin
            n_w <= n_w + 1; last_wdata <= axi_wdata; last_wstrb <= axi_wstrb;
        end
        if (axi_bvalid && axi_bready)   n_b  <= n_b + 1;
        if (axi_arvalid && axi_arready) begin n_ar <= n_ar + 1; last_araddr <= axi_araddr; end
        if (axi_rvalid && axi_rready)   n_r  <= n_r + 1;
        if (axi_awvalid || axi_wvalid || axi_bready || axi_arvalid || axi_rready)
            n_vld <= n_vld + 1;
        if (axi_arvalid) n_arv <= n_arv + 1;
        if (axi_wvalid && !axi_awvalid) n_wonly <= n_wonly + 1;
        if ((axi_awvalid && p_awv && axi_awaddr != p_awaddr) ||
            (axi_wvalid  && p_wv  && axi_wdata  != p_wdata)  ||
            (axi_arvalid && p_arv && axi_araddr != p_araddr))
            n_unstable <= n_unstable + 1;
        p_awv <= axi_awvalid; p_wv <= axi_wvalid; p_arv <= axi_arvalid;
        p_awaddr <= axi_awaddr; p_wdata <= axi_wdata; p_araddr <= axi_araddr;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for completion. lat counts the request
    // cycle as 1, so reg_ready seen in the 4th cycle gives lat=4.
    task automatic run(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int lat);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        reg_valid = 1'b1; reg_write = wr; reg_addr = a; reg_wdata = d; reg_wstrb = s;
        lat = 1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (reg_ready) seen = 1'b1;
        end
        chk("completion", {31'd0, seen}, 32'd1);
        reg_valid = 1'b0;
        @(negedge clk);
        chk("ready_pulse_width", {31'd0, reg_ready}, 32'd0);
    endtask

    int lat;
    int s_aw, s_w, s_b, s_ar, s_vld, s_arv, s_wonly;
    int rdy_seen;
    logic got_bready;

    task automatic snap();
        s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar;
        s_vld = n_vld; s_arv = n_arv; s_wonly = n_wonly;
    endtask

    initial begin
        rst_n = 1'b0; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0;
        reg_wdata = '0; reg_wstrb = '0;
        axi_bresp = 2'b00; axi_rresp = 2'b00; axi_rdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, reg_ready}, 32'd0);
        chk("rst_error", {31'd0, reg_error}, 32'd0);
        chk("rst_rdata", reg_rdata, 32'd0);
        chk("rst_valids", {27'd0, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 32'd0);
        chk("rst_addrs", axi_awaddr | axi_araddr | axi_wdata | {28'd0, axi_wstrb}, 32'd0);
        rst_n = 1'b1;

        // zero-wait write
        snap();
        run(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, lat);
        chk("wr_lat", lat, 32'd4);
        chk("wr_error", {31'd0, reg_error}, 32'd0);
        chk("wr_rdata", reg_rdata, 32'd0);
        chk("wr_aw_hs", n_aw - s_aw, 32'd1);
        chk("wr_w_hs", n_w - s_w, 32'd1);
        chk("wr_b_hs", n_b - s_b, 32'd1);
        chk("wr_awaddr", last_awaddr, 32'h4);
        chk("wr_wdata", last_wdata, 32'hDEADBEEF);
        chk("wr_wstrb", {28'd0, last_wstrb}, 32'hF);

        // read with rvalid 3 cycles late
        r_dly = 3; axi_rdata = 32'h12345678;
        snap();
        run(1'b0, 32'h8, 32'h0, 4'h0, lat);
        chk("rd_lat", lat, 32'd7);
        chk("rd_rdata", reg_rdata, 32'h12345678);
        chk("rd_error", {31'd0, reg_error}, 32'd0);
        chk("rd_araddr", last_araddr, 32'h8);
        chk("rd_ar_hs", n_ar - s_ar, 32'd1);
        r_dly = 0;

        // write with wready 2 cycles after awready
        w_dly = 2;
        snap();
        run(1'b1, 32'h10, 32'hA5A55A5A, 4'h3, lat);
        chk("wsplit_lat", lat, 32'd6);
        chk("wsplit_wonly_cycles", n_wonly - s_wonly, 32'd2);
        chk("wsplit_aw_hs", n_aw - s_aw, 32'd1);
        chk("wsplit_w_hs", n_w - s_w, 32'd1);
        chk("wsplit_b_hs", n_b - s_b, 32'd1);
        chk("wsplit_wstrb", {28'd0, last_wstrb}, 32'h3);
        chk("wsplit_error", {31'd0, reg_error}, 32'd0);
        w_dly = 0;

        // write with SLVERR
        axi_bresp = 2'b10;
        run(1'b1, 32'h20, 32'h1, 4'h1, lat);
        chk("wr_slverr_error", {31'd0, reg_error}, 32'd1);
        chk("wr_slverr_rdata", reg_rdata, 32'd0);
        axi_bresp = 2'b00;

        // read with SLVERR: data still returned
        axi_rresp = 2'b10; axi_rdata = 32'hCAFEF00D;
        run(1'b0, 32'hC, 32'h0, 4'h0, lat);
        chk("rd_slverr_error", {31'd0, reg_error}, 32'd1);
        chk("rd_slverr_rdata", reg_rdata, 32'hCAFEF00D);
        axi_rresp = 2'b00; axi_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("hold_rdata", reg_rdata, 32'hCAFEF00D);
        chk("hold_error", {31'd0, reg_error}, 32'd1);

        // misaligned read: no bus activity
        snap();
        run(1'b0, 32'h6, 32'h0, 4'h0, lat);
        chk("mis_lat", lat, 32'd2);
        chk("mis_bus_cycles", n_vld - s_vld, 32'd0);
        chk("mis_error", {31'd0, reg_error}, 32'd1);
        chk("mis_rdata", reg_rdata, 32'd0);

        // read timeout: arready never comes
        ar_dly = 100000; axi_rdata = 32'hFFFFFFFF;
        snap();
        run(1'b0, 32'h40, 32'h0, 4'h0, lat);
        chk("tmo_arvalid_cycles", n_arv - s_arv, 32'd8);
        chk("tmo_lat", lat, 32'd10);
        chk("tmo_error", {31'd0, reg_error}, 32'd1);
        chk("tmo_rdata", reg_rdata, 32'd0);
        chk("tmo_arvalid_low", {31'd0, axi_arvalid}, 32'd0);
        ar_dly = 0;

        // reset while waiting for B
        b_dly = 5; got_bready = 1'b0; rdy_seen = 0;
        @(negedge clk);
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 32'h30;
        reg_wdata = 32'h55; reg_wstrb = 4'hF;
        for (int i = 0; i < 20 && !got_bready; i++) begin
            @(negedge clk);
            if (axi_bready) got_bready = 1'b1;
        end
        chk("rstmid_reached_wr_resp", {31'd0, got_bready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valids", {27'd0, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 32'd0);
        chk("rstmid_resp", {reg_rdata[29:0], reg_ready, reg_error}, 32'd0);
        chk("rstmid_addrs", axi_awaddr | axi_wdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (reg_ready) rdy_seen++;
        end
        reg_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (reg_ready) rdy_seen++;
        end
        chk("rstmid_no_ready", rdy_seen, 32'd0);
        b_dly = 0;

        // normal read after reset
        axi_rdata = 32'hA5A50001;
        run(1'b0, 32'h0, 32'h0, 4'h0, lat);
        chk("post_rst_lat", lat, 32'd4);
        chk("post_rst_rdata", reg_rdata, 32'hA5A50001);
        chk("post_rst_error", {31'd0, reg_error}, 32'd0);
        chk("addr_stability", n_unstable, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
